player_shot_move_collision: RTL and testbench

//  Upward-travelling player (tank) shot; counterpart of the downward alien shot mover.

---
 rtl/space_inv_pkg.sv | 23 ++
 rtl/key_rise_detect.sv | 24 ++
 rtl/player_shot_move_collision.sv | 158 +++++++++++++++
 tb/tb_player_shot_move_collision.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/space_inv_pkg.sv
// Shared fixed-point, screen and shot-state definitions for the space-invaders movers.
package space_inv_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FP_SHIFT               = 6;
  localparam int FP_W                   = 21;
  localparam int POS_W                  = 11;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } shot_state_t;

  // Pixel position to 1/64-pixel fixed point (sign-extended, arithmetic left shift).
  function automatic logic signed [FP_W-1:0] to_fp(input logic signed [POS_W-1:0] pos);
    return {{(FP_W-POS_W-FP_SHIFT){pos[POS_W-1]}}, pos, {FP_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/key_rise_detect.sv
// Registers a key level once and emits a one-clk pulse on its rising edge.
module key_rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic clr_i,
  input  logic key_i,
  output logic rise_o
);

  logic key_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_q <= 1'b0;
    end else if (clr_i) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_i;
    end
  end

  assign rise_o = key_i & ~key_q;

endmodule

// File: rtl/player_shot_move_collision.sv
// Upward player shot: launch on fire edge, per-frame climb, kill on hit or top limit.
// Optional re-arm delay after a kill is enabled by defining PLAYER_SHOT_COOLDOWN_EN.
module player_shot_move_collision
  import space_inv_pkg::*;
#(
  parameter int SHOT_Y_SPEED = 128,
  parameter int PLAYER_WIDTH = 32,
  parameter int SHOT_HEIGHT  = 16,
  parameter int TOP_LIMIT    = 8
`ifdef PLAYER_SHOT_COOLDOWN_EN
  , parameter int COOLDOWN_FRAMES = 8
`endif
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               playGame,
  input  logic               fireKey,
  input  logic signed [10:0] playerXPosition,
  input  logic signed [10:0] playerYPosition,
  input  logic               shotCollision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               shotAlive,
  output logic               shotFired,
  output logic [7:0]         hitCount
);

  localparam logic signed [FP_W-1:0] SPEED_FP = FP_W'(SHOT_Y_SPEED);
  localparam logic signed [FP_W-1:0] X_OFS_FP = FP_W'((PLAYER_WIDTH / 2 - 1) * FIXED_POINT_MULTIPLIER);
  localparam logic signed [FP_W-1:0] Y_OFS_FP = FP_W'(SHOT_HEIGHT * FIXED_POINT_MULTIPLIER);
  // Integer Y <= TOP_LIMIT is the same as fixed Y < (TOP_LIMIT+1)*64.
  localparam logic signed [FP_W-1:0] TOP_EXCL_FP = FP_W'((TOP_LIMIT + 1) * FIXED_POINT_MULTIPLIER);

  shot_state_t             state_q, state_d;
  logic signed [FP_W-1:0]  x_q, x_d;
  logic signed [FP_W-1:0]  y_q, y_d;
  logic signed [FP_W-1:0]  y_step;
  logic                    alive_q, alive_d;
  logic                    fired_q, fired_d;
  logic [7:0]              hits_q, hits_d;
  logic                    kill;
  logic                    fire_edge;

`ifdef PLAYER_SHOT_COOLDOWN_EN
  localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  key_rise_detect u_fire_edge (
    .clk    (clk),
    .resetN (resetN),
    .clr_i  (~playGame),
    .key_i  (fireKey),
    .rise_o (fire_edge)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      alive_q <= 1'b0;
      fired_q <= 1'b0;
      hits_q  <= '0;
`ifdef PLAYER_SHOT_COOLDOWN_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      alive_q <= alive_d;
      fired_q <= fired_d;
      hits_q  <= hits_d;
`ifdef PLAYER_SHOT_COOLDOWN_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fired_d = 1'b0;
    hits_d  = hits_q;
    kill    = 1'b0;
    y_step  = y_q - SPEED_FP;
`ifdef PLAYER_SHOT_COOLDOWN_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (fire_edge) begin
          x_d     = to_fp(playerXPosition) + X_OFS_FP;
          y_d     = to_fp(playerYPosition) - Y_OFS_FP;
          fired_d = 1'b1;
          state_d = FLYING;
        end
      end
      FLYING: begin
        // A hit takes priority over the frame step, so Y freezes where it was hit.
        if (shotCollision) begin
          kill = 1'b1;
          if (hits_q != 8'hFF) begin
            hits_d = hits_q + 8'd1;
          end
        end else if (startOfFrame) begin
          y_d = y_step;
          if (y_step < TOP_EXCL_FP) begin
            kill = 1'b1;
          end
        end
        if (kill) begin
`ifdef PLAYER_SHOT_COOLDOWN_EN
          state_d = COOLDOWN;
          cnt_d   = CNT_W'(COOLDOWN_FRAMES);
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PLAYER_SHOT_COOLDOWN_EN
      COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (startOfFrame) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    alive_d = (state_q == FLYING) && !kill;

    if (!playGame) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      alive_d = 1'b0;
      fired_d = 1'b0;
      hits_d  = '0;
`ifdef PLAYER_SHOT_COOLDOWN_EN
      cnt_d   = '0;
`endif
    end
  end

  assign topLeftX  = x_q[FP_SHIFT +: POS_W];
  assign topLeftY  = y_q[FP_SHIFT +: POS_W];
  assign shotAlive = alive_q;
  assign shotFired = fired_q;
  assign hitCount  = hits_q;

endmodule

// File: tb/tb_player_shot_move_collision.sv
// Table-driven plus scoreboard bench for the player shot mover (default build).
module tb_player_shot_move_collision;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame, playGame, fireKey, shotCollision;
  logic signed [10:0] playerXPosition, playerYPosition;
  logic signed [10:0] topLeftX, topLeftY;
  logic               shotAlive, shotFired;
  logic [7:0]         hitCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  player_shot_move_collision dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .playGame        (playGame),
    .fireKey         (fireKey),
    .playerXPosition (playerXPosition),
    .playerYPosition (playerYPosition),
    .shotCollision   (shotCollision),
    .topLeftX        (topLeftX),
    .topLeftY        (topLeftY),
    .shotAlive       (shotAlive),
    .shotFired       (shotFired),
    .hitCount        (hitCount)
  );

  typedef struct {
    logic               alive;
    logic               fired;
    logic signed [10:0] x;
    logic signed [10:0] y;
    logic [7:0]         hits;
  } exp_t;

  typedef struct {
    logic               pg, fk, sof, col;
    logic signed [10:0] px, py;
    exp_t               e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  function automatic exp_t mke(input logic a, input logic f, input int x, input int y, input int h);
    exp_t e;
    e.alive = a;
    e.fired = f;
    e.x     = 11'(x);
    e.y     = 11'(y);
    e.hits  = 8'(h);
    return e;
  endfunction

  function automatic vec_t mkv(input logic pg, input logic fk, input logic sof, input logic col,
                               input int px, input int py, input exp_t e);
    vec_t v;
    v.pg = pg; v.fk = fk; v.sof = sof; v.col = col;
    v.px = 11'(px); v.py = 11'(py);
    v.e  = e;
    return v;
  endfunction

  function automatic void chk(input string name, input logic [10:0] got, input logic [10:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endfunction

  // Drive at a negedge, let one posedge pass, return at the following negedge.
  task automatic drive(input logic pg, input logic fk, input logic sof, input logic col,
                       input int px, input int py);
    playGame        = pg;
    fireKey         = fk;
    startOfFrame    = sof;
    shotCollision   = col;
    playerXPosition = 11'(px);
    playerYPosition = 11'(py);
    @(negedge clk);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 11'd1, 11'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_alive"}, 11'(shotAlive), 11'(e.alive));
      chk({tag, "_fired"}, 11'(shotFired), 11'(e.fired));
      chk({tag, "_x"},     topLeftX,       e.x);
      chk({tag, "_y"},     topLeftY,       e.y);
      chk({tag, "_hits"},  11'(hitCount),  11'(e.hits));
      $display("txn %s: alive=%0b fired=%0b x=%0d y=%0d hits=%0d", tag,
               shotAlive, shotFired, topLeftX, topLeftY, hitCount);
    end
  endtask

  initial begin
    int fired_cnt;
    int yv;
    resetN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    #2;
    sb_q.push_back(mke(0, 0, 0, 0, 0));
    sb_check("reset");

    // Rows: {playGame, fireKey, sof, collision, playerX, playerY, expected after the edge}
    vecs[0]  = mkv(1, 0, 0, 0, 300, 440, mke(0, 0,   0,   0, 0));
    vecs[1]  = mkv(1, 1, 0, 0, 300, 440, mke(0, 1, 315, 424, 0));
    vecs[2]  = mkv(1, 1, 0, 0, 300, 440, mke(1, 0, 315, 424, 0));
    vecs[3]  = mkv(1, 1, 1, 0, 300, 440, mke(1, 0, 315, 422, 0));
    vecs[4]  = mkv(1, 1, 0, 0, 300, 440, mke(1, 0, 315, 422, 0));
    vecs[5]  = mkv(1, 0, 1, 0, 300, 440, mke(1, 0, 315, 420, 0));
    vecs[6]  = mkv(1, 1, 0, 0, 300, 440, mke(1, 0, 315, 420, 0));
    vecs[7]  = mkv(1, 1, 0, 1, 300, 440, mke(0, 0, 315, 420, 1));
    vecs[8]  = mkv(1, 0, 0, 0, 300, 440, mke(0, 0, 315, 420, 1));
    vecs[9]  = mkv(1, 1, 0, 1, 100, 300, mke(0, 1, 115, 284, 1));
    vecs[10] = mkv(1, 1, 1, 1, 100, 300, mke(0, 0, 115, 284, 2));
    vecs[11] = mkv(0, 0, 0, 0, 100, 300, mke(0, 0,   0,   0, 0));
    vecs[12] = mkv(1, 1, 0, 0, -10,  20, mke(0, 1,   5,   4, 0));
    vecs[13] = mkv(1, 1, 1, 0, -10,  20, mke(0, 0,   5,   2, 0));
    vecs[14] = mkv(1, 0, 0, 0, 300, 440, mke(0, 0,   5,   2, 0));
    vecs[15] = mkv(1, 1, 0, 0, 300, 440, mke(0, 1, 315, 424, 0));
    vecs[16] = mkv(1, 1, 0, 0, 300, 440, mke(1, 0, 315, 424, 0));
    vecs[17] = mkv(0, 1, 0, 0, 300, 440, mke(0, 0,   0,   0, 0));

    resetN = 1'b1;
    for (int i = 0; i < 18; i++) begin
      sb_q.push_back(vecs[i].e);
      drive(vecs[i].pg, vecs[i].fk, vecs[i].sof, vecs[i].col, vecs[i].px, vecs[i].py);
      sb_check($sformatf("vec%0d", i));
    end

    // Held key across 20 frames: one launch, 2 px per frame.
    fired_cnt = 0;
    drive(1, 0, 0, 0, 300, 440);
    sb_q.push_back(mke(0, 1, 315, 424, 0));
    drive(1, 1, 0, 0, 300, 440);
    fired_cnt += int'(shotFired);
    sb_check("hold_launch");
    for (int f = 1; f <= 20; f++) begin
      sb_q.push_back(mke(1, 0, 315, 424 - 2 * f, 0));
      drive(1, 1, 1, 0, 300, 440);
      fired_cnt += int'(shotFired);
      sb_check($sformatf("hold_frame%0d", f));
      drive(1, 1, 0, 0, 300, 440);
      fired_cnt += int'(shotFired);
    end
    chk("hold_single_fire", 11'(fired_cnt), 11'd1);
    sb_q.push_back(mke(0, 0, 315, 384, 1));
    drive(1, 1, 0, 1, 300, 440);
    sb_check("hold_hit");

    // Climb to the top limit from Y=24 (player Y 40): dies on reaching 8.
    drive(1, 0, 0, 0, 300, 40);
    sb_q.push_back(mke(0, 1, 315, 24, 1));
    drive(1, 1, 0, 0, 300, 40);
    sb_check("top_launch");
    drive(1, 0, 0, 0, 300, 40);
    for (int f = 1; f <= 8; f++) begin
      yv = 24 - 2 * f;
      sb_q.push_back(mke(f < 8, 0, 315, yv, 1));
      drive(1, 0, 1, 0, 300, 40);
      sb_check($sformatf("top_frame%0d", f));
    end
`ifndef PLAYER_SHOT_COOLDOWN_EN
    sb_q.push_back(mke(0, 1, 315, 424, 1));
    drive(1, 1, 0, 0, 300, 440);
    sb_check("rearm_next_clk");
`endif
    drive(0, 0, 0, 0, 0, 0);

    // Saturation: 256 launches each hit once.
    for (int h = 1; h <= 256; h++) begin
      drive(1, 0, 0, 0, 300, 440);
      drive(1, 1, 0, 0, 300, 440);
      if (h >= 254) sb_q.push_back(mke(0, 0, 315, 424, (h > 255) ? 255 : h));
      drive(1, 1, 0, 1, 300, 440);
      if (h >= 254) sb_check($sformatf("sat_hit%0d", h));
    end

    // Async reset mid-flight clears outputs before the next clock edge.
    drive(1, 0, 0, 0, 300, 440);
    drive(1, 1, 0, 0, 300, 440);
    sb_q.push_back(mke(1, 0, 315, 422, 255));
    drive(1, 1, 1, 0, 300, 440);
    sb_check("pre_async");
    #2 resetN = 1'b0;
    #1;
    sb_q.push_back(mke(0, 0, 0, 0, 0));
    sb_check("async_reset");
    @(negedge clk);
    resetN = 1'b1;
    sb_q.push_back(mke(0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 300, 440);
    sb_check("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
